ro_measure_ctrl: RTL

//  Sequencer for the ring-oscillator experiment datapath. On a start command it serially loads the
//  16-bit oscillator config shift chain and sets the clock-source select. It then clears and gates
//  the oscillator counter for a programmed window of clk cycles and returns the synchronised count.

---
 rtl/ro_meas_pkg.sv | 21 ++
 rtl/ro_measure_ctrl_gray_sync.sv | 51 +++++
 rtl/ro_measure_ctrl.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/ro_meas_pkg.sv
// Shared types and constants for the ring-oscillator measurement sequencer.
// Holds the state encoding, clock-source codes and the fixed clear length.
package ro_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    CLEAR,
    COUNT,
    DRAIN
  } state_e;

  localparam logic [2:0] SRC_DIV4 = 3'b000;
  localparam logic [2:0] SRC_RO3  = 3'b001;
  localparam logic [2:0] SRC_RO5  = 3'b010;
  localparam logic [2:0] SRC_RAW  = 3'b011;

  localparam int CLEAR_CYC = 4;

endpackage

// File: rtl/ro_measure_ctrl_gray_sync.sv
// Multi-flop synchroniser for the Gray-coded oscillator count.
// The last synced stage is converted to binary and registered.
module gray_sync #(
  parameter int W      = 16,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] gray_in,
  output logic [W-1:0] bin_out
);

  logic [W-1:0] sync_q [STAGES];
  logic [W-1:0] sync_d [STAGES];
  logic [W-1:0] bin_d;
  logic [W-1:0] bin_q;

  // Shift the Gray word through the synchroniser chain.
  always_comb begin
    sync_d[0] = gray_in;
    for (int i = 1; i < STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    bin_d = '0;
    for (int i = 0; i < W; i++) begin
      bin_d[i] = ^(sync_q[STAGES-1] >> i);
    end
  end

  // Register synchroniser stages and the binary output.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= '0;
      end
      bin_q <= '0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      bin_q <= bin_d;
    end
  end

  assign bin_out = bin_q;

endmodule

// File: rtl/ro_measure_ctrl.sv
// Sequencer: loads the oscillator config chain, gates the counter for
// a programmed window and returns the synchronised binary count.
module ro_measure_ctrl
  import ro_meas_pkg::*;
#(
  parameter int CFG_W       = 16,
  parameter int CNT_W       = 16,
  parameter int WIN_W       = 16,
  parameter int SHIFT_HALF  = 2,
  parameter int SETTLE_CYC  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CFG_W-1:0] cfg_word,
  input  logic [2:0]       src_sel,
  input  logic [WIN_W-1:0] win_len,
  input  logic             result_ack,
  input  logic [CNT_W-1:0] osc_cnt_gray,
  output logic             busy,
  output logic             shift_clk,
  output logic             shift_dta,
  output logic [2:0]       clk_source,
  output logic             osc_clr,
  output logic             osc_gate,
  output logic [CNT_W-1:0] result,
  output logic             result_valid,
  output logic             overflow
);

  localparam int PH_W  = 16;
  localparam int BIT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;

  state_e           state_q, state_d;
  logic [PH_W-1:0]  ph_q, ph_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [CFG_W-1:0] sr_q, sr_d;
  logic [CNT_W-1:0] prev_q, prev_d;
  logic             arm_q, arm_d;
  logic             busy_q, busy_d;
  logic             shift_clk_q, shift_clk_d;
  logic             shift_dta_q, shift_dta_d;
  logic [2:0]       clk_source_q, clk_source_d;
  logic             osc_clr_q, osc_clr_d;
  logic             osc_gate_q, osc_gate_d;
  logic [CNT_W-1:0] result_q, result_d;
  logic             result_valid_q, result_valid_d;
  logic             overflow_q, overflow_d;
  logic [CNT_W-1:0] cnt_bin;

  gray_sync #(
    .W      (CNT_W),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .gray_in (osc_cnt_gray),
    .bin_out (cnt_bin)
  );

  // Next-state and registered-output logic for the whole sequence.
  always_comb begin
    state_d        = state_q;
    ph_d           = ph_q;
    bit_d          = bit_q;
    win_d          = win_q;
    sr_d           = sr_q;
    prev_d         = cnt_bin;
    arm_d          = (state_q == COUNT) || (state_q == DRAIN);
    busy_d         = busy_q;
    shift_clk_d    = 1'b0;
    shift_dta_d    = shift_dta_q;
    clk_source_d   = clk_source_q;
    osc_clr_d      = 1'b0;
    osc_gate_d     = 1'b0;
    result_d       = result_q;
    result_valid_d = result_valid_q & ~result_ack;
    overflow_d     = overflow_q;
    // Late samples keep arriving through DRAIN, so a wrap is watched there too.
    if (arm_q && (state_q == COUNT || state_q == DRAIN) && cnt_bin < prev_q) begin
      overflow_d = 1'b1;
    end
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = LOAD;
          ph_d           = PH_W'(2 * SHIFT_HALF - 1);
          bit_d          = BIT_W'(CFG_W - 1);
          shift_dta_d    = cfg_word[CFG_W-1];
          sr_d           = cfg_word << 1;
          clk_source_d   = src_sel;
          win_d          = (win_len == '0) ? WIN_W'(1) : win_len;
          result_valid_d = 1'b0;
          overflow_d     = 1'b0;
          busy_d         = 1'b1;
        end
      end
      LOAD: begin
        if (ph_q != '0) begin
          ph_d        = ph_q - 1'b1;
          shift_clk_d = (ph_q - 1'b1) < PH_W'(SHIFT_HALF);
        end else if (bit_q != '0) begin
          ph_d        = PH_W'(2 * SHIFT_HALF - 1);
          bit_d       = bit_q - 1'b1;
          shift_dta_d = sr_q[CFG_W-1];
          sr_d        = sr_q << 1;
        end else begin
          state_d     = SETTLE;
          ph_d        = PH_W'(SETTLE_CYC - 1);
          shift_dta_d = 1'b0;
        end
      end
      SETTLE: begin
        if (ph_q != '0) begin
          ph_d = ph_q - 1'b1;
        end else begin
          state_d   = CLEAR;
          ph_d      = PH_W'(CLEAR_CYC - 1);
          osc_clr_d = 1'b1;
        end
      end
      CLEAR: begin
        if (ph_q != '0) begin
          ph_d      = ph_q - 1'b1;
          osc_clr_d = 1'b1;
        end else begin
          state_d    = COUNT;
          osc_gate_d = 1'b1;
        end
      end
      COUNT: begin
        if (win_q != WIN_W'(1)) begin
          win_d      = win_q - 1'b1;
          osc_gate_d = 1'b1;
        end else begin
          state_d = DRAIN;
          ph_d    = PH_W'(SYNC_STAGES + 1);
        end
      end
      DRAIN: begin
        if (ph_q != '0) begin
          ph_d = ph_q - 1'b1;
        end else begin
          state_d        = IDLE;
          result_d       = cnt_bin;
          result_valid_d = 1'b1;
          busy_d         = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      ph_q           <= '0;
      bit_q          <= '0;
      win_q          <= '0;
      sr_q           <= '0;
      prev_q         <= '0;
      arm_q          <= 1'b0;
      busy_q         <= 1'b0;
      shift_clk_q    <= 1'b0;
      shift_dta_q    <= 1'b0;
      clk_source_q   <= SRC_DIV4;
      osc_clr_q      <= 1'b0;
      osc_gate_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overflow_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      ph_q           <= ph_d;
      bit_q          <= bit_d;
      win_q          <= win_d;
      sr_q           <= sr_d;
      prev_q         <= prev_d;
      arm_q          <= arm_d;
      busy_q         <= busy_d;
      shift_clk_q    <= shift_clk_d;
      shift_dta_q    <= shift_dta_d;
      clk_source_q   <= clk_source_d;
      osc_clr_q      <= osc_clr_d;
      osc_gate_q     <= osc_gate_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overflow_q     <= overflow_d;
    end
  end

  assign busy         = busy_q;
  assign shift_clk    = shift_clk_q;
  assign shift_dta    = shift_dta_q;
  assign clk_source   = clk_source_q;
  assign osc_clr      = osc_clr_q;
  assign osc_gate     = osc_gate_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overflow     = overflow_q;

endmodule
